// File: rtl/in_conditioner.sv
// ---------------------------------------------------------------------------
// in_conditioner
//
// Conditions an asynchronous raw input (push-button or line level) into a
// clean, debounced level suitable for driving a downstream counter's "in"
// input. raw_in is first brought into the clk domain through a flop chain.
// The synchronised sample then goes to a four-state qualification FSM. A
// level change is accepted only after DEBOUNCE_CYCLES consecutive stable
// samples. Changes that revert before that point are counted as glitches.
//
// Parameters
//   SYNC_STAGES      synchroniser depth (2..4)
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a change
//   CNT_W            width of the qualification counter
//
// Ports
//   clk         single clock, all state updates on its rising edge
//   reset       asynchronous, active-low reset
//   raw_in      asynchronous raw input
//   enable      1 = qualify raw_in, 0 = hold the accepted level
//   glitch_clr  synchronous clear of glitch_cnt (wins over a glitch event)
//   in_out      registered debounced level
//   rise_pulse  registered one-cycle pulse on an accepted 0->1 change
//   fall_pulse  registered one-cycle pulse on an accepted 1->0 change
//   glitch_cnt  saturating count of rejected (too short) level changes
//   state       FSM state: 00 IDLE_LO, 01 QUAL_HI, 10 IDLE_HI, 11 QUAL_LO
// ---------------------------------------------------------------------------
module in_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    input  logic       enable,
    input  logic       glitch_clr,
    output logic       in_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        QUAL_HI = 2'b01,
        IDLE_HI = 2'b10,
        QUAL_LO = 2'b11
    } state_t;

    // The acceptance sample is the one where the counter already holds
    // DEBOUNCE_CYCLES-1. The entry sample from IDLE counts as the first.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       GLITCH_MAX = 8'hFF;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t           state_q;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;

    logic       in_next;
    logic       rise_next;
    logic       fall_next;
    logic       glitch_event;
    logic [7:0] glitch_next;

    // Synchroniser chain. This chain is the only logic that sees raw_in.
    // It keeps shifting while enable is low, so its contents are current
    // when qualification resumes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State register. This block also registers every output, so in_out
    // and both pulses come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE_LO;
            cnt_q      <= '0;
            in_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state_q    <= state_next;
            cnt_q      <= cnt_next;
            in_out     <= in_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            glitch_cnt <= glitch_next;
        end
    end

    // Next-state logic. The two qualification states are mirror images.
    // A qualify state returns to its idle state when the sample reverts
    // or when enable drops. An idle state holds while enable is low, so
    // qualification restarts from a zero count once enable returns.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        case (state_q)
            IDLE_LO: begin
                if (enable && s) begin
                    state_next = QUAL_HI;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            QUAL_HI: begin
                if (!enable || !s) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (enable && !s) begin
                    state_next = QUAL_LO;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            QUAL_LO: begin
                if (!enable || s) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic. Acceptance drives the level and exactly one pulse.
    // A reversion while enabled is a glitch event. An abort caused by
    // enable dropping is silent.
    always_comb begin
        in_next      = in_out;
        rise_next    = 1'b0;
        fall_next    = 1'b0;
        glitch_event = 1'b0;
        case (state_q)
            QUAL_HI: begin
                if (enable && s && cnt_q == CNT_LAST) begin
                    in_next   = 1'b1;
                    rise_next = 1'b1;
                end else if (enable && !s) begin
                    glitch_event = 1'b1;
                end
            end
            QUAL_LO: begin
                if (enable && !s && cnt_q == CNT_LAST) begin
                    in_next   = 1'b0;
                    fall_next = 1'b1;
                end else if (enable && s) begin
                    glitch_event = 1'b1;
                end
            end
            default: begin
                in_next = in_out;
            end
        endcase

        // glitch_clr takes priority over a simultaneous glitch event.
        // The count saturates at 255 rather than wrapping.
        glitch_next = glitch_cnt;
        if (glitch_clr) begin
            glitch_next = '0;
        end else if (glitch_event && glitch_cnt != GLITCH_MAX) begin
            glitch_next = glitch_cnt + 8'd1;
        end
    end

    assign state = state_q;

endmodule
